// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encodings, PC step,
// NOP word, the prefetch queue entry layout and the PC alignment helper.
package ifu_pkg;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DISCARD = 2'd2;

    localparam logic [31:0] PC_STEP  = 32'd4;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifq_entry_t;

    function automatic logic [31:0] align_pc(input logic [31:0] pc);
        return {pc[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifq_fifo.sv
// Prefetch queue: synchronous FIFO of {pc, inst} entries with push, pop and a
// flush that empties it on the same edge.
module ifq_fifo
    import ifu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  ifq_entry_t                 wdata,
    output ifq_entry_t                 rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    ifq_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign empty   = (count == '0);
    assign push_ok = push && (count != DEPTH_C);
    assign pop_ok  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage is not reset; empty/count gate every read, so stale words are never seen.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: fetch PC, one-outstanding imem req/ack, prefetch queue
// and redirect flush. Define IFQ_BYPASS_EN to forward an ack straight to decode when the queue is empty.
module inst_fetch_unit
    import ifu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       imem_req,
    output logic [31:0]                imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_data,
    input  logic                       redirect,
    input  logic [31:0]                redirect_pc,
    output logic                       inst_valid,
    output logic [31:0]                inst,
    output logic [31:0]                inst_pc,
    output logic [31:0]                inst_pc4,
    input  logic                       inst_ready,
    output logic [$clog2(DEPTH+1)-1:0] q_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [1:0]  state, state_nx;
    logic [31:0] fetch_pc, fetch_pc_nx;
    logic [31:0] addr_nx;
    logic        ack_push;
    logic        push;
    logic        pop;
    logic        bypass;
    logic        fifo_empty;
    ifq_entry_t  head;

    assign imem_req = (state != ST_IDLE);

`ifdef IFQ_BYPASS_EN
    assign bypass = (state == ST_WAIT) && imem_ack && !redirect && fifo_empty;
`else
    assign bypass = 1'b0;
`endif

    // A bypassed word that decode takes this cycle must not also land in the queue.
    assign push = ack_push && !(bypass && inst_ready);
    assign pop  = !fifo_empty && inst_ready && !redirect;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_nx    = state;
        fetch_pc_nx = fetch_pc;
        addr_nx     = imem_addr;
        ack_push    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (redirect) begin
                    fetch_pc_nx = align_pc(redirect_pc);
                end else if (q_count < DEPTH_C) begin
                    state_nx = ST_WAIT;
                    addr_nx  = fetch_pc;
                end
            end
            ST_WAIT: begin
                if (redirect) begin
                    fetch_pc_nx = align_pc(redirect_pc);
                    state_nx    = imem_ack ? ST_IDLE : ST_DISCARD;
                end else if (imem_ack) begin
                    ack_push    = 1'b1;
                    fetch_pc_nx = fetch_pc + PC_STEP;
                    state_nx    = ST_IDLE;
                end
            end
            ST_DISCARD: begin
                if (redirect) fetch_pc_nx = align_pc(redirect_pc);
                if (imem_ack) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            fetch_pc  <= RESET_PC;
            imem_addr <= RESET_PC;
        end else begin
            state     <= state_nx;
            fetch_pc  <= fetch_pc_nx;
            imem_addr <= addr_nx;
        end
    end

    ifq_fifo #(.DEPTH(DEPTH)) u_ifq (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata ({imem_addr, imem_data}),
        .rdata (head),
        .empty (fifo_empty),
        .count (q_count)
    );

    assign inst_valid = !fifo_empty || bypass;
    assign inst       = bypass ? imem_data : (fifo_empty ? NOP_WORD : head.inst);
    assign inst_pc    = bypass ? imem_addr : (fifo_empty ? 32'h0 : head.pc);
    assign inst_pc4   = inst_pc + PC_STEP;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: fetch sequencing, full queue, redirects,
// push+pop, async reset, PC wrap, and the IFQ_BYPASS_EN forwarding path.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [31:0] inst_pc4;
    logic        inst_ready;
    logic [2:0]  q_count;

    int n_checks = 0;
    int n_fail   = 0;

    inst_fetch_unit #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst_valid  (inst_valid),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_pc4    (inst_pc4),
        .inst_ready  (inst_ready),
        .q_count     (q_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        imem_ack   = 1'b0;
        imem_data  = 32'h0;
        redirect   = 1'b0;
        inst_ready = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    // Answers the outstanding request for addr, then lets the FSM issue again.
    task automatic ack_word(input logic [31:0] addr, input logic [31:0] data);
        check("ack_word req", 32'(imem_req), 32'd1);
        check("ack_word addr", imem_addr, addr);
        imem_ack  = 1'b1;
        imem_data = data;
        tick();
        imem_ack = 1'b0;
        tick();
    endtask

    initial begin
        reset       = 1'b1;
        imem_ack    = 1'b0;
        imem_data   = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst req", 32'(imem_req), 32'd0);
        check("rst addr", imem_addr, 32'h0);
        check("rst valid", 32'(inst_valid), 32'd0);
        check("rst q_count", 32'(q_count), 32'd0);
        check("rst inst", inst, 32'h0);
        check("rst inst_pc", inst_pc, 32'h0);
        check("rst inst_pc4", inst_pc4, 32'h4);

        // 1: sequential fetch, ack latency 1, decode always ready
        reset      = 1'b0;
        inst_ready = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t1 req", 32'(imem_req), 32'd1);
            check("t1 addr", imem_addr, 32'(i * 4));
            imem_ack  = 1'b1;
            imem_data = 32'hA000_0000 + 32'(i);
            #1;
`ifdef IFQ_BYPASS_EN
            check("t1 bypass valid", 32'(inst_valid), 32'd1);
            check("t1 bypass pc", inst_pc, 32'(i * 4));
`else
            check("t1 valid before push", 32'(inst_valid), 32'd0);
`endif
            tick();
            imem_ack = 1'b0;
`ifndef IFQ_BYPASS_EN
            check("t1 valid", 32'(inst_valid), 32'd1);
            check("t1 inst_pc", inst_pc, 32'(i * 4));
            check("t1 inst", inst, 32'hA000_0000 + 32'(i));
            check("t1 inst_pc4", inst_pc4, 32'(i * 4 + 4));
`endif
            tick();
        end

        // 2: decode stalled, queue fills to DEPTH, one pop reopens fetch
        do_reset();
        tick();
        for (int i = 0; i < 4; i++) ack_word(32'(i * 4), 32'hB000_0000 + 32'(i));
        check("t2 q_count full", 32'(q_count), 32'd4);
        check("t2 req blocked", 32'(imem_req), 32'd0);
        check("t2 head pc", inst_pc, 32'h0);
        check("t2 head valid", 32'(inst_valid), 32'd1);
        tick();
        check("t2 req still blocked", 32'(imem_req), 32'd0);
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        check("t2 q_count after pop", 32'(q_count), 32'd3);
        check("t2 head pc after pop", inst_pc, 32'h4);
        tick();
        check("t2 req reopened", 32'(imem_req), 32'd1);
        check("t2 addr 0x10", imem_addr, 32'h10);

        // 3: redirect while waiting for 0x8, ack arrives later and is dropped
        do_reset();
        tick();
        ack_word(32'h0, 32'hC000_0000);
        ack_word(32'h4, 32'hC000_0004);
        check("t3 q_count pre", 32'(q_count), 32'd2);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        check("t3 flushed", 32'(q_count), 32'd0);
        check("t3 valid flushed", 32'(inst_valid), 32'd0);
        check("t3 req held", 32'(imem_req), 32'd1);
        check("t3 addr held", imem_addr, 32'h8);
        tick();
        tick();
        imem_ack  = 1'b1;
        imem_data = 32'hDEAD_0008;
        tick();
        imem_ack = 1'b0;
        check("t3 req after discard", 32'(imem_req), 32'd0);
        check("t3 q_count after discard", 32'(q_count), 32'd0);
        check("t3 valid after discard", 32'(inst_valid), 32'd0);
        tick();
        check("t3 req target", 32'(imem_req), 32'd1);
        check("t3 addr target", imem_addr, 32'h40);
        imem_ack  = 1'b1;
        imem_data = 32'hC000_0040;
        tick();
        imem_ack = 1'b0;
        check("t3 target valid", 32'(inst_valid), 32'd1);
        check("t3 target pc", inst_pc, 32'h40);
        check("t3 target pc4", inst_pc4, 32'h44);
        check("t3 target inst", inst, 32'hC000_0040);
        tick();

        // 4: redirect and ack in the same cycle, unaligned target
        check("t4 req", 32'(imem_req), 32'd1);
        check("t4 addr", imem_addr, 32'h44);
        imem_ack    = 1'b1;
        imem_data   = 32'hDEAD_0044;
        redirect    = 1'b1;
        redirect_pc = 32'h103;
        tick();
        imem_ack = 1'b0;
        redirect = 1'b0;
        check("t4 q_count", 32'(q_count), 32'd0);
        check("t4 valid", 32'(inst_valid), 32'd0);
        check("t4 req dropped", 32'(imem_req), 32'd0);
        tick();
        check("t4 req target", 32'(imem_req), 32'd1);
        check("t4 addr aligned", imem_addr, 32'h100);

        // 5: two entries queued, push and pop in the same cycle
        ack_word(32'h100, 32'hE000_0100);
        ack_word(32'h104, 32'hE000_0104);
        check("t5 q_count pre", 32'(q_count), 32'd2);
        check("t5 addr", imem_addr, 32'h108);
        imem_ack   = 1'b1;
        imem_data  = 32'hE000_0108;
        inst_ready = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("t5 q_count push+pop", 32'(q_count), 32'd2);
        check("t5 head pc", inst_pc, 32'h104);
        check("t5 head inst", inst, 32'hE000_0104);
        tick();
        inst_ready = 1'b0;
        check("t5 q_count after pop", 32'(q_count), 32'd1);
        check("t5 next pc", inst_pc, 32'h108);
        check("t5 next inst", inst, 32'hE000_0108);

        // 6: reset asserted while a request is outstanding
        check("t6 req before reset", 32'(imem_req), 32'd1);
        reset = 1'b1;
        #1;
        check("t6 req async drop", 32'(imem_req), 32'd0);
        check("t6 addr reset", imem_addr, 32'h0);
        check("t6 q_count reset", 32'(q_count), 32'd0);
        check("t6 valid reset", 32'(inst_valid), 32'd0);
        tick();
        reset      = 1'b0;
        inst_ready = 1'b1;
        tick();
        check("t6 req", 32'(imem_req), 32'd1);
        check("t6 addr", imem_addr, 32'h0);
        imem_ack  = 1'b1;
        imem_data = 32'hF000_0000;
        #1;
`ifdef IFQ_BYPASS_EN
        check("t6 bypass valid", 32'(inst_valid), 32'd1);
        check("t6 bypass pc", inst_pc, 32'h0);
        check("t6 bypass inst", inst, 32'hF000_0000);
        check("t6 bypass q_count", 32'(q_count), 32'd0);
`else
        check("t6 no bypass", 32'(inst_valid), 32'd0);
`endif
        inst_ready = 1'b0;
        #1;
        tick();
        imem_ack = 1'b0;
        check("t6 queued q_count", 32'(q_count), 32'd1);

        // 7: fetch PC wraps from the top of the address space
        do_reset();
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        check("t7 no issue on redirect", 32'(imem_req), 32'd0);
        tick();
        check("t7 req", 32'(imem_req), 32'd1);
        check("t7 addr top", imem_addr, 32'hFFFF_FFFC);
        imem_ack  = 1'b1;
        imem_data = 32'h1234_5678;
        tick();
        imem_ack = 1'b0;
        check("t7 inst_pc", inst_pc, 32'hFFFF_FFFC);
        check("t7 inst_pc4 wrap", inst_pc4, 32'h0);
        tick();
        check("t7 addr wrapped", imem_addr, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
